// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch-stage program counter with return-address stack
module pc_ras_unit #(
    parameter int              AW         = 32,
    parameter int              STEP       = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hit,
    input  logic                           branch_taken,
    input  logic [AW-1:0]                  branch_target,
    input  logic                           jump,
    input  logic [AW-1:0]                  jump_target,
    input  logic                           link,
    input  logic                           ret,
    input  logic [AW-1:0]                  ret_target,
    output logic [AW-1:0]                  curr_instruction_address,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] stack [RAS_DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] top_m1;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;
    logic          set_of;
    logic          set_uf;

    // top points at the next slot to write; the most recent entry sits one below it
    assign seq_pc = pc + AW'(STEP);
    assign top_m1 = top - PW'(1);

    // Redirect priority: branch, then return, then jump, else sequential
    always_comb begin
        next_pc = seq_pc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_of  = 1'b0;
        set_uf  = 1'b0;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (ret) begin
            if (count != '0) begin
                next_pc = stack[top_m1];
                do_pop  = 1'b1;
            end else begin
                next_pc = ret_target;
                set_uf  = 1'b1;
            end
        end else if (jump) begin
            next_pc = jump_target;
            if (link) begin
                do_push = 1'b1;
                set_of  = ras_full;
            end
        end
    end

    // All state advances on the falling edge, and only when the I-cache hits
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_ADDR;
            top           <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (hit) begin
            pc            <= next_pc;
            ras_overflow  <= ras_overflow | set_of;
            ras_underflow <= ras_underflow | set_uf;
            if (do_push) begin
                // When full, the write lands on the oldest entry and count saturates
                stack[top] <= seq_pc;
                top        <= top + PW'(1);
                if (count != CW'(RAS_DEPTH)) begin
                    count <= count + CW'(1);
                end
            end else if (do_pop) begin
                top   <= top_m1;
                count <= count - CW'(1);
            end
        end
    end

    assign curr_instruction_address = pc;
    assign ras_count                = count;
    assign ras_empty                = (count == '0);
    assign ras_full                 = (count == CW'(RAS_DEPTH));

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the instruction-fetch stage: holds the current fetch address and selects the next one from sequential increment, taken branch, jump, or return. A return-address stack (RAS) of configurable depth predicts `jr $ra` targets. The PC advances only on instruction-cache hit and updates on the falling edge of `clk`, matching the fetch-stage convention.

## Interface
- `AW`, 32, address width in bits.
- `STEP`, 4, sequential increment in bytes.
- `RESET_ADDR`, 0, PC value after reset.
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥2.

One clock; reset is asynchronous and active-high.

- `clk`  in  1  clock; all state updates on falling edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hit`  in  1  I-cache hit; 0 = stall, all state held.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  AW  branch destination.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  AW  jump destination.
- `link`  in  1  with `jump`: push PC+STEP onto RAS (jal).
- `ret`  in  1  return: pop RAS for target.
- `ret_target`  in  AW  register-file $ra, used only when RAS empty.
- `curr_instruction_address`  out  AW  current fetch PC.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- `ras_empty`  out  1  `ras_count`==0.
- `ras_full`  out  1  `ras_count`==RAS_DEPTH.
- `ras_overflow`  out  1  sticky: push occurred while full.
- `ras_underflow`  out  1  sticky: pop occurred while empty.

## Operation
- Reset (async, any time, including mid-stall): PC=RESET_ADDR, `ras_count`=0, top pointer=0, all entries 0, both sticky flags 0. `ras_empty`=1, `ras_full`=0.
- `hit`=0: PC, RAS, pointers, flags all held; all redirect inputs ignored (upstream keeps them asserted until hit).
- `hit`=1: next PC chosen by fixed priority:
  1. `branch_taken` -> `branch_target`; RAS untouched.
  2. `ret` -> RAS top if not empty (pop: count-1); else `ret_target`, set `ras_underflow`, count stays 0.
  3. `jump` -> `jump_target`; if `link`, push PC+STEP.
  4. else PC+STEP.
- `link` without `jump`: ignored. Lower-priority requests in the same cycle are dropped entirely (no push/pop side effects).
- Push when full: circular overwrite of oldest entry, top pointer advances modulo RAS_DEPTH, count stays RAS_DEPTH, `ras_overflow` set.
- Pointer arithmetic modulo RAS_DEPTH; PC arithmetic modulo 2^AW (PC+STEP from 2^AW-STEP wraps to 0), no carry out.
- Sticky flags clear only on reset.

## Timing
- Single-cycle latency: inputs sampled at falling edge N; new PC and RAS state visible after that edge, stable until edge N+1.
- All outputs registered or decoded purely from registers; no combinational input-to-output path.
- Reset deassertion: first update occurs at the first falling edge with `rst`=0.
- Push and pop never happen in the same cycle (priority guarantees it).

## Test plan
- Reset then 3 cycles `hit`=1, no redirects -> PC 0, 4, 8, 0xC; `ras_empty`=1.
- PC=0x100, `jump`=1,`link`=1,`jump_target`=0x400 -> PC=0x400, count=1; next cycle `ret`=1 -> PC=0x104, count=0.
- RAS_DEPTH=4: five jal pushes from PCs 0x0,0x10,0x20,0x30,0x40 -> count=4, `ras_overflow`=1; four rets return 0x44,0x34,0x24,0x14; fifth ret with `ret_target`=0x999 -> PC=0x999, `ras_underflow`=1.
- `hit`=0 for 3 cycles with `branch_taken`=1 -> PC unchanged; `hit`=1 -> PC=`branch_target`; `branch_taken`+`ret`+`jump`/`link` together -> branch target, RAS count unchanged.
- RESET_ADDR=0xFFFFFFFC, one hit cycle -> PC=0x0; assert `rst` mid-sequence with count=3 -> PC=0xFFFFFFFC, count=0, flags 0 immediately, without a clock edge.
